// File: rtl/mem_stage_ctrl_if.sv
// Memory-side request bus for mem_stage_ctrl: single-cycle Rd/Wr strobes out,
// done/busy/error status and read data back from the cache + stall memory.
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memDataIn;
  logic              memRd;
  logic              memWr;
  logic [DATA_W-1:0] memDataOut;
  logic              memDone;
  logic              memStall;
  logic              memErr;

  modport master (
    output memAddr, memDataIn, memRd, memWr,
    input  memDataOut, memDone, memStall, memErr
  );

  modport slave (
    input  memAddr, memDataIn, memRd, memWr,
    output memDataOut, memDone, memStall, memErr
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage request controller: one strobe per load/store, pipeline stall until memDone,
// sticky error reporting and LBI bypass. Define MEM_TIMEOUT_EN to add the WAIT watchdog.
module mem_stage_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int ALIGN_CHECK = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] aluOut,
  input  logic [DATA_W-1:0] wrData,
  input  logic              lbi,
  input  logic              halt,
  output logic [DATA_W-1:0] memoryOut,
  output logic              stall,
  output logic              err,
  mem_stage_ctrl_if.master  memBus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } stateE;

  stateE             state;
  logic              opRead;
  logic [DATA_W-1:0] loadData;

  logic req;
  logic misaligned;
  logic legal;
  logic accept;

`ifdef MEM_TIMEOUT_EN
  localparam int WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WdW-1:0] wdCnt;
`endif

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    req        = 1'b0;
    misaligned = 1'b0;
    legal      = 1'b0;
    accept     = 1'b0;
    stall      = 1'b0;
    memoryOut  = loadData;

    req        = (memRead | memWrite) & ~lbi & ~halt;
    misaligned = (ALIGN_CHECK != 0) && aluOut[0];
    legal      = ~(memRead & memWrite) & ~misaligned;
    accept     = (state == IDLE) & req & legal;
    // Reset must drop the hold immediately, even while a request is still presented.
    stall      = rst & (accept | (state == ISSUE) | (state == WAIT));
    if (rst && lbi && (state == IDLE)) begin
      memoryOut = DATA_W'(aluOut);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      opRead           <= 1'b0;
      loadData         <= '0;
      err              <= 1'b0;
      memBus.memRd     <= 1'b0;
      memBus.memWr     <= 1'b0;
      memBus.memAddr   <= '0;
      memBus.memDataIn <= '0;
`ifdef MEM_TIMEOUT_EN
      wdCnt            <= '0;
`endif
    end else begin
      if (memBus.memErr) begin
        err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            memBus.memAddr   <= aluOut;
            memBus.memDataIn <= wrData;
            opRead           <= memRead;
            memBus.memRd     <= memRead;
            memBus.memWr     <= memWrite;
            state            <= ISSUE;
          end else if (req) begin
            // Conflicting or misaligned request: flag it and never touch memory.
            err <= 1'b1;
          end
        end

        ISSUE: begin
          if (!memBus.memStall) begin
            memBus.memRd <= 1'b0;
            memBus.memWr <= 1'b0;
            if (memBus.memDone) begin
              state <= DONE;
              if (opRead) begin
                loadData <= memBus.memDataOut;
              end
            end else begin
              state <= WAIT;
`ifdef MEM_TIMEOUT_EN
              wdCnt <= '0;
`endif
            end
          end
        end

        WAIT: begin
          if (memBus.memDone) begin
            state <= DONE;
            if (opRead) begin
              loadData <= memBus.memDataOut;
            end
`ifdef MEM_TIMEOUT_EN
          end else if (wdCnt == WdW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            wdCnt <= wdCnt + 1'b1;
`endif
          end
        end

        // One stall-free cycle lets the pipeline advance before the next request is seen.
        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: table of single-cycle IDLE vectors plus
// scripted multi-cycle accesses (hit, busy store, WAIT, async reset, watchdog).
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic [15:0] aluOut;
  logic [15:0] wrData;
  logic        lbi;
  logic        halt;
  logic [15:0] memoryOut;
  logic        stall;
  logic        err;

  int checks;
  int fails;

  mem_stage_ctrl_if #(.DATA_W(16), .ADDR_W(16)) memBus ();

  mem_stage_ctrl #(
    .DATA_W(16),
    .ADDR_W(16),
    .ALIGN_CHECK(1),
    .TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .memRead  (memRead),
    .memWrite (memWrite),
    .aluOut   (aluOut),
    .wrData   (wrData),
    .lbi      (lbi),
    .halt     (halt),
    .memoryOut(memoryOut),
    .stall    (stall),
    .err      (err),
    .memBus   (memBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, actual=running required=finished");
    $fatal(1, "global timeout");
  end

  typedef struct {
    bit          doRst;
    bit          rd;
    bit          wr;
    bit          lbiV;
    bit          haltV;
    bit          memErrV;
    logic [15:0] addr;
    bit          expStall;
    logic [15:0] expOut;
    bit          expErr;
    bit          expStrobe;
  } vecT;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic clearInputs();
    memRead           = 1'b0;
    memWrite          = 1'b0;
    aluOut            = 16'h0000;
    wrData            = 16'h0000;
    lbi               = 1'b0;
    halt              = 1'b0;
    memBus.memDataOut = 16'h0000;
    memBus.memDone    = 1'b0;
    memBus.memStall   = 1'b0;
    memBus.memErr     = 1'b0;
  endtask

  // Called just after a rising edge; pulses reset well clear of both edges.
  task automatic resetPulse();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  // Accept at cycle 0, memStall for nStall ISSUE cycles, nWait WAIT cycles,
  // memDone in cycle L = 1+nStall+nWait; request held through L.
  task automatic runAccess(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] data, input logic [15:0] rdata,
                           input int nStall, input int nWait,
                           output logic [15:0] stallPat, output logic [15:0] rdPat,
                           output logic [15:0] wrPat, output logic [15:0] outAtDone,
                           output logic [15:0] addrSeen, output logic [15:0] dataSeen);
    int last;
    last      = 1 + nStall + nWait;
    stallPat  = '0;
    rdPat     = '0;
    wrPat     = '0;
    outAtDone = 'x;
    addrSeen  = 'x;
    dataSeen  = 'x;
    for (int c = 0; c <= last + 2; c++) begin
      memRead           = rd && (c <= last);
      memWrite          = wr && (c <= last);
      aluOut            = addr;
      wrData            = data;
      memBus.memStall   = (c >= 1) && (c <= nStall);
      memBus.memDone    = (c == last);
      memBus.memDataOut = (c == last) ? rdata : 16'hDEAD;
      @(negedge clk);
      stallPat[c] = stall;
      rdPat[c]    = memBus.memRd;
      wrPat[c]    = memBus.memWr;
      if (c == 1) begin
        addrSeen = memBus.memAddr;
        dataSeen = memBus.memDataIn;
      end
      if (c == last + 1) outAtDone = memoryOut;
      @(posedge clk);
      #1;
    end
    clearInputs();
  endtask

  vecT vecs[11];
  logic [15:0] sp, rp, wp, od, as, ds;
  bit toEn;

  initial begin
    checks = 0;
    fails  = 0;
`ifdef MEM_TIMEOUT_EN
    toEn = 1'b1;
`else
    toEn = 1'b0;
`endif
    //           rst rd wr lbi hlt mErr addr      stall out      err strobe
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0};
    vecs[1]  = '{0, 1, 0, 1, 0, 0, 16'h00FF, 0, 16'h00FF, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 1, 0, 16'h0010, 0, 16'h0000, 0, 0};
    vecs[3]  = '{0, 1, 1, 0, 1, 0, 16'h0030, 0, 16'h0000, 0, 0};
    vecs[4]  = '{0, 1, 1, 0, 0, 0, 16'h0040, 0, 16'h0000, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0};
    vecs[6]  = '{1, 1, 0, 0, 0, 0, 16'h0011, 0, 16'h0000, 1, 0};
    vecs[7]  = '{0, 0, 1, 1, 0, 0, 16'h1234, 0, 16'h1234, 1, 0};
    vecs[8]  = '{1, 0, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 1, 0};
    vecs[9]  = '{1, 1, 0, 1, 0, 0, 16'h0011, 0, 16'h0011, 0, 0};
    vecs[10] = '{1, 0, 1, 0, 0, 0, 16'h0013, 0, 16'h0000, 1, 0};

    clearInputs();
    rst = 1'b0;
    #12;
    check("reset_stall", stall, 0);
    check("reset_err", err, 0);
    check("reset_memoryOut", memoryOut, 16'h0000);
    check("reset_strobes", {memBus.memRd, memBus.memWr}, 0);
    check("reset_memAddr", memBus.memAddr, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].doRst) resetPulse();
      memRead       = vecs[i].rd;
      memWrite      = vecs[i].wr;
      lbi           = vecs[i].lbiV;
      halt          = vecs[i].haltV;
      memBus.memErr = vecs[i].memErrV;
      aluOut        = vecs[i].addr;
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), stall, vecs[i].expStall);
      check($sformatf("vec%0d_memoryOut", i), memoryOut, vecs[i].expOut);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_err", i), err, vecs[i].expErr);
      check($sformatf("vec%0d_strobe", i), memBus.memRd | memBus.memWr, vecs[i].expStrobe);
      clearInputs();
    end

    // Load hit: memDone in the ISSUE cycle.
    resetPulse();
    runAccess(1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 0, sp, rp, wp, od, as, ds);
    check("hit_stallPat", sp, 16'h0003);
    check("hit_rdPat", rp, 16'h0002);
    check("hit_wrPat", wp, 16'h0000);
    check("hit_memAddr", as, 16'h0010);
    check("hit_memoryOut", od, 16'hBEEF);

    // Store into busy memory: 3 memStall cycles, then 2 WAIT cycles.
    runAccess(0, 1, 16'h0020, 16'h1234, 16'h7777, 3, 2, sp, rp, wp, od, as, ds);
    check("store_stallPat", sp, 16'h007F);
    check("store_wrPat", wp, 16'h001E);
    check("store_rdPat", rp, 16'h0000);
    check("store_memAddr", as, 16'h0020);
    check("store_memDataIn", ds, 16'h1234);
    check("store_memoryOut_kept", od, 16'hBEEF);

    // Load with one busy cycle and one WAIT cycle.
    runAccess(1, 0, 16'h0100, 16'h0000, 16'h0F0F, 1, 1, sp, rp, wp, od, as, ds);
    check("wait_stallPat", sp, 16'h000F);
    check("wait_rdPat", rp, 16'h0006);
    check("wait_memoryOut", od, 16'h0F0F);
    check("no_err_after_accesses", err, 0);

    // Async reset while the controller sits in WAIT.
    memRead = 1'b1;
    aluOut  = 16'h0200;
    @(posedge clk);
    #1;
    check("rstmid_issue_memRd", memBus.memRd, 1);
    @(posedge clk);
    #1;
    check("rstmid_wait_stall", stall, 1);
    rst = 1'b0;
    #1;
    check("rstmid_stall", stall, 0);
    check("rstmid_strobes", {memBus.memRd, memBus.memWr}, 0);
    check("rstmid_memoryOut", memoryOut, 16'h0000);
    memRead = 1'b0;
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    runAccess(1, 0, 16'h0300, 16'h0000, 16'h5A5A, 0, 0, sp, rp, wp, od, as, ds);
    check("rstmid_fresh_stallPat", sp, 16'h0003);
    check("rstmid_fresh_rdPat", rp, 16'h0002);
    check("rstmid_fresh_memoryOut", od, 16'h5A5A);

    // Memory never answers: watchdog (TIMEOUT=8) or indefinite WAIT.
    resetPulse();
    for (int c = 0; c <= 12; c++) begin
      memRead = toEn ? (c <= 9) : 1'b1;
      aluOut  = 16'h0400;
      @(negedge clk);
      if (c == 9) begin
        check("to_c9_stall", stall, 1);
        check("to_c9_err", err, 0);
      end
      if (c == 10) begin
        check("to_c10_stall", stall, toEn ? 1'b0 : 1'b1);
        check("to_c10_err", err, toEn ? 1'b1 : 1'b0);
      end
      if (c == 12) check("to_c12_stall", stall, toEn ? 1'b0 : 1'b1);
      @(posedge clk);
      #1;
    end
    clearInputs();
    resetPulse();
    #1;
    check("final_err_cleared", err, 0);
    check("final_stall", stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
